// File: rtl/map_table_pkg.sv
// Shared types for the register-renaming map table: ROB/RS packets and the
// per-register entry, plus the source-lookup helper used by both read ports.
package map_table_pkg;
  localparam int ARCH_REGS   = 32;
  localparam int REG_IDX_LEN = $clog2(ARCH_REGS);
  localparam int ROB_IDX_LEN = 5;
  localparam int ROB_SIZE    = 2 ** ROB_IDX_LEN;

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0] rob_tail;
    logic                   squash;
  } rob_mt_packet_t;

  typedef struct packed {
    logic                   mapped;
    logic [ROB_IDX_LEN-1:0] tag;
    logic                   ready;
  } mt_entry_t;

  typedef struct packed {
    logic                   rs1_mapped;
    logic [ROB_IDX_LEN-1:0] rs1_tag;
    logic                   rs1_ready;
    logic                   rs2_mapped;
    logic [ROB_IDX_LEN-1:0] rs2_tag;
    logic                   rs2_ready;
  } mt_rs_packet_t;

  // Ready includes a same-cycle CDB hit so a consumer never misses a broadcast.
  function automatic mt_entry_t src_lookup(mt_entry_t e, logic is_x0, logic cdb_valid,
                                           logic [ROB_IDX_LEN-1:0] cdb_tag);
    mt_entry_t r;
    r = '0;
    if (!is_x0 && e.mapped) begin
      r.mapped = 1'b1;
      r.tag    = e.tag;
      r.ready  = e.ready | (cdb_valid & (cdb_tag == e.tag));
    end
    return r;
  endfunction
endpackage

// File: rtl/map_table_if.sv
// Dispatch / CDB / retire inputs and RS-facing outputs of the map table.
interface map_table_if;
  import map_table_pkg::*;

  rob_mt_packet_t                    rob_mt;
  logic                              dispatch_enable;
  logic [REG_IDX_LEN-1:0]            dest_reg_idx;
  logic [REG_IDX_LEN-1:0]            rs1_idx;
  logic [REG_IDX_LEN-1:0]            rs2_idx;
  logic                              cdb_valid;
  logic [ROB_IDX_LEN-1:0]            cdb_tag;
  logic                              retire_valid;
  logic [REG_IDX_LEN-1:0]            retire_reg_idx;
  logic [ROB_IDX_LEN-1:0]            retire_tag;
  mt_rs_packet_t                     mt_rs;
  mt_entry_t [ARCH_REGS-1:0]         mt_entries;

  modport master (
    output rob_mt, dispatch_enable, dest_reg_idx, rs1_idx, rs2_idx,
           cdb_valid, cdb_tag, retire_valid, retire_reg_idx, retire_tag,
    input  mt_rs, mt_entries
  );

  modport slave (
    input  rob_mt, dispatch_enable, dest_reg_idx, rs1_idx, rs2_idx,
           cdb_valid, cdb_tag, retire_valid, retire_reg_idx, retire_tag,
    output mt_rs, mt_entries
  );
endinterface

// File: rtl/map_table_entry.sv
// One architectural register's mapping. Priority: squash > dispatch > retire > CDB;
// reset is applied in the register itself and overrides everything.
module map_table_entry
  import map_table_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  logic                   disp_hit,
  input  logic [ROB_IDX_LEN-1:0] disp_tag,
  input  logic                   ret_hit,
  input  logic [ROB_IDX_LEN-1:0] ret_tag,
  input  logic                   cdb_valid,
  input  logic [ROB_IDX_LEN-1:0] cdb_tag,
  output mt_entry_t              entry
);
  mt_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (squash)
      entry_d = '0;
    else if (disp_hit)
      entry_d = '{mapped: 1'b1, tag: disp_tag, ready: 1'b0};
    // A tag mismatch means a younger rename owns the register; keep it.
    else if (ret_hit && entry_q.mapped && entry_q.tag == ret_tag)
      entry_d = '0;
    else if (cdb_valid && entry_q.mapped && entry_q.tag == cdb_tag)
      entry_d.ready = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign entry = entry_q;
endmodule

// File: rtl/map_table.sv
// Register-renaming map table: one entry per architectural register, with
// two combinational source-lookup ports that forward a same-cycle CDB hit.
module map_table
  import map_table_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  map_table_if.slave  mt
);
  mt_entry_t [ARCH_REGS-1:0] entries;
  mt_entry_t                 src1, src2;

  for (genvar i = 0; i < ARCH_REGS; i++) begin : g_ent
    localparam logic [REG_IDX_LEN-1:0] IDX = REG_IDX_LEN'(i);
    logic disp_hit, ret_hit;

    // x0 is hard-wired, so it can never be renamed.
    assign disp_hit = mt.dispatch_enable && (mt.dest_reg_idx == IDX) && (i != 0);
    assign ret_hit  = mt.retire_valid && (mt.retire_reg_idx == IDX);

    map_table_entry u_ent (
      .clock     (clock),
      .reset     (reset),
      .squash    (mt.rob_mt.squash),
      .disp_hit  (disp_hit),
      .disp_tag  (mt.rob_mt.rob_tail),
      .ret_hit   (ret_hit),
      .ret_tag   (mt.retire_tag),
      .cdb_valid (mt.cdb_valid),
      .cdb_tag   (mt.cdb_tag),
      .entry     (entries[i])
    );
  end

  always_comb begin
    src1 = src_lookup(entries[mt.rs1_idx], mt.rs1_idx == '0, mt.cdb_valid, mt.cdb_tag);
    src2 = src_lookup(entries[mt.rs2_idx], mt.rs2_idx == '0, mt.cdb_valid, mt.cdb_tag);
  end

  assign mt.mt_rs = '{rs1_mapped: src1.mapped, rs1_tag: src1.tag, rs1_ready: src1.ready,
                      rs2_mapped: src2.mapped, rs2_tag: src2.tag, rs2_ready: src2.ready};
  assign mt.mt_entries = entries;
endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- Register-renaming map table for the P6 core. It maps each architectural register to the ROB entry that will produce its value, and tracks whether that value is already complete.
- Sits between the ID/dispatch stage, the ROB (consumer of ROB_MT_PACKET), the CDB and the reservation stations.
- Supplies source tags and ready bits to the RS at dispatch, and clears mappings on retire and on squash.

Parameters:
- ARCH_REGS, 32, number of architectural registers (x0 is never mapped)
- ROB_IDX_LEN, 5, width of a ROB tag (ROB_SIZE = 2**ROB_IDX_LEN = 32)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rob_mt  in  ROB_MT_PACKET  .rob_tail = ROB index allocated to the instruction dispatched this cycle; .squash = mispredict flush
- dispatch_enable  in  1  an instruction is dispatched this cycle (already gated by !rob_full)
- dest_reg_idx  in  5  destination architectural register of the dispatching instruction
- rs1_idx  in  5  source register 1 of the dispatching instruction
- rs2_idx  in  5  source register 2 of the dispatching instruction
- cdb_valid  in  1  a CDB broadcast is present this cycle
- cdb_tag  in  ROB_IDX_LEN  ROB index being broadcast
- retire_valid  in  1  ROB head retires this cycle
- retire_reg_idx  in  5  destination register of the retiring entry
- retire_tag  in  ROB_IDX_LEN  ROB index of the retiring entry
- mt_rs  out  MT_RS_PACKET  {rs1_mapped, rs1_tag, rs1_ready, rs2_mapped, rs2_tag, rs2_ready}
- mt_entries  out  MT_ENTRY[ARCH_REGS]  debug view of the table state

Behaviour:
- Storage: one MT_ENTRY {mapped, tag, ready} per architectural register.
- Reset: all entries {0,0,0} at the first clock edge with reset high. mt_rs derives from the table, so every mt_rs field reads 0 after reset.
- Reset asserted mid-operation overrides squash, dispatch, retire and CDB in that cycle.
- Lookup (combinational, zero latency), per source s:
  - s_mapped = entry[s].mapped
  - s_tag = entry[s].tag when mapped, else 0
  - s_ready = mapped & (entry[s].ready | (cdb_valid & cdb_tag == entry[s].tag)); this is same-cycle CDB forwarding.
  - Index 0 always returns mapped=0.
- Lookups read the pre-edge state. If rs1_idx == dest_reg_idx in the same cycle, the old mapping is returned (the instruction depends on the previous producer).
- Dispatch: when dispatch_enable and dest_reg_idx != 0, entry[dest] <= {1, rob_mt.rob_tail, 0} at the edge.
- CDB: when cdb_valid, every mapped entry with tag == cdb_tag gets ready <= 1 at the edge.
- Retire: when retire_valid, entry[retire_reg_idx].mapped and entry.tag == retire_tag, the entry is cleared to {0,0,0}. A tag mismatch means the register has since been renamed; the entry is left unchanged.
- Same-entry priority: reset > squash > dispatch > retire > CDB.
  - Dispatch and retire to the same register in one cycle: the new mapping wins.
  - Dispatch and CDB to the same register in one cycle: the new mapping is written with ready=0.
- Squash (rob_mt.squash=1): every entry is cleared at the edge; dispatch, retire and CDB are ignored that cycle. mt_rs in the squash cycle still reflects pre-edge state; the RS discards it.
- ROB tags wrap modulo 32. Tag 0 is a legal tag; mapped, not tag value, indicates validity.
- No backpressure. The block never stalls.

Decomposition:
- Shared package (sys_defs):
  - MT_ENTRY struct
  - MT_RS_PACKET struct
  - reuse of the existing ROB_MT_PACKET and the `ROB_IDX_LEN / `ROB_SIZE macros
- A per-entry sub-module mt_entry (update logic for one register, with the priority above) is natural. The top module generates 32 instances plus two read muxes.

Test Plan:
1. Reset, then read rs1=3, rs2=5 -> both mapped=0, tag=0, ready=0; mt_entries all zero.
2. Dispatch dest=3 with rob_tail=1; next cycle rs1=3 -> mapped=1, tag=1, ready=0.
   - Same-cycle variant: dispatch dest=3 with rs1=3 on an empty table -> rs1 mapped=0.
3. Table holds r3->tag 1. Drive cdb_valid with cdb_tag=1 and read rs1=3 in the same cycle -> ready=1 combinationally; next cycle entry[3].ready=1 with no CDB.
4. Dispatch r2->tag 2, then r2->tag 4. Retire r2 with tag 2 -> r2 stays mapped to tag 4. Retire r2 with tag 4 -> r2 unmapped.
5. Map r1->5, r2->6, r7->7, then assert squash together with dispatch dest=9, rob_tail=8 -> next cycle all entries unmapped, including r9.
6. Dispatch dest=0 with rob_tail=3 -> entry[0] stays unmapped. Dispatch r4->31, then r4->0 (tag wrap) -> r4 mapped with tag 0, ready 0.
